// File: rtl/generador_pulsos_pkg.sv
// constantes_rtc: constants shared by the RTC controller front panel.
//   FRECUENCIA_HZ       system clock frequency
//   RETARDO_DEF         default press-to-first-repeat delay (0.5 s)
//   PERIODO_DEF         default repeat interval (0.1 s)
//   estado_t            state encoding for generador_pulsos
//   maximo()            helper used to size counters
package constantes_rtc;

    localparam int unsigned FRECUENCIA_HZ = 100_000_000;
    localparam int unsigned RETARDO_DEF   = FRECUENCIA_HZ / 2;
    localparam int unsigned PERIODO_DEF   = FRECUENCIA_HZ / 10;

    typedef enum logic [1:0] {
        REPOSO = 2'b00,
        ESPERA = 2'b01,
        REPITE = 2'b10
    } estado_t;

    function automatic int unsigned maximo(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/generador_pulsos.sv
// generador_pulsos: turns the debounced button level into one-clock command
// pulses: one on press, then auto-repeat while the button stays held.
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   entrada    debounced button level, synchronous to clk
//   pulso      registered one-clock command strobe
//   mantenido  registered flag, high while auto-repeating
module generador_pulsos
    import constantes_rtc::*;
#(
    parameter int unsigned RETARDO      = RETARDO_DEF,
    parameter int unsigned PERIODO      = PERIODO_DEF,
    parameter bit          HABILITA_REP = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic entrada,
    output logic pulso,
    output logic mantenido
);

    localparam int unsigned ANCHO = $clog2(maximo(RETARDO, PERIODO));
    localparam logic [ANCHO-1:0] FIN_RETARDO = ANCHO'(RETARDO - 1);
    localparam logic [ANCHO-1:0] FIN_PERIODO = ANCHO'(PERIODO - 1);

    estado_t          estado;
    logic [ANCHO-1:0] cnt;
    logic             entrada_q;
    logic             subida;

    assign subida = entrada & ~entrada_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            estado    <= REPOSO;
            cnt       <= '0;
            pulso     <= 1'b0;
            mantenido <= 1'b0;
            // Held-through-reset button must be released before it counts as a press.
            entrada_q <= 1'b1;
        end else begin
            entrada_q <= entrada;
            case (estado)
                REPOSO: begin
                    mantenido <= 1'b0;
                    if (subida) begin
                        pulso  <= 1'b1;
                        cnt    <= '0;
                        estado <= ESPERA;
                    end else begin
                        pulso <= 1'b0;
                    end
                end

                ESPERA: begin
                    if (!entrada) begin
                        estado <= REPOSO;
                        pulso  <= 1'b0;
                        cnt    <= '0;
                    end else if (cnt == FIN_RETARDO) begin
                        pulso <= HABILITA_REP;
                        if (HABILITA_REP) begin
                            cnt       <= '0;
                            estado    <= REPITE;
                            mantenido <= 1'b1;
                        end
                        // Without repeat, cnt parks at the terminal value until release.
                    end else begin
                        cnt   <= cnt + 1'b1;
                        pulso <= 1'b0;
                    end
                end

                REPITE: begin
                    if (!entrada) begin
                        estado    <= REPOSO;
                        pulso     <= 1'b0;
                        cnt       <= '0;
                        mantenido <= 1'b0;
                    end else if (cnt == FIN_PERIODO) begin
                        pulso     <= 1'b1;
                        cnt       <= '0;
                        mantenido <= 1'b1;
                    end else begin
                        cnt       <= cnt + 1'b1;
                        pulso     <= 1'b0;
                        mantenido <= 1'b1;
                    end
                end

                default: begin
                    estado    <= REPOSO;
                    cnt       <= '0;
                    pulso     <= 1'b0;
                    mantenido <= 1'b0;
                end
            endcase
        end
    end

endmodule
